weights_stream_loader: RTL and testbench



---
 rtl/weights_pkg.sv | 26 ++
 rtl/weights_stream_loader_if.sv | 35 +++
 rtl/weights_addr_counter.sv | 69 ++++++
 rtl/weights_stream_loader.sv | 121 ++++++++++++
 tb/tb_weights_stream_loader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/weights_pkg.sv
// -----------------------------------------------------------------------------
// weights_pkg
// Definitions shared by the weights RAM, the stream loader and the replay
// stage:
//   - default matrix geometry (WEIGHTS_ROWS x WEIGHTS_COLS words of WEIGHTS_DW)
//   - loader FSM state type
//   - addr_width(): address width for a given depth, never less than 1 bit
// -----------------------------------------------------------------------------
package weights_pkg;

    localparam int unsigned WEIGHTS_ROWS = 4;
    localparam int unsigned WEIGHTS_COLS = 8;
    localparam int unsigned WEIGHTS_DW   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    // A single-entry dimension still needs a 1-bit address port.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/weights_stream_loader_if.sv
// -----------------------------------------------------------------------------
// weights_stream_loader_if
// Valid/ready weight-word stream feeding the loader.
//   s_valid : producer has a word
//   s_data  : weight word (DATA_WIDTH bits)
//   s_last  : producer marks its final word
//   s_ready : consumer can accept a word
// Modports: master = producer, slave = consumer (the loader).
// -----------------------------------------------------------------------------
interface weights_stream_loader_if
    import weights_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WEIGHTS_DW
);

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/weights_addr_counter.sv
// -----------------------------------------------------------------------------
// weights_addr_counter
// Row-major (row, col) position counter over a NUM_ROWS x NUM_COLS matrix.
//   clk, rst : clock, synchronous active-high reset (position -> (0,0))
//   clr_i    : return to (0,0); has priority over inc_i
//   inc_i    : advance one position; col wraps into row, the final position
//              wraps to (0,0) so the address never leaves the matrix
//   row_o    : current row
//   col_o    : current column
//   final_o  : current position is (NUM_ROWS-1, NUM_COLS-1)
// -----------------------------------------------------------------------------
module weights_addr_counter
    import weights_pkg::*;
#(
    parameter int unsigned NUM_ROWS = WEIGHTS_ROWS,
    parameter int unsigned NUM_COLS = WEIGHTS_COLS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr_i,
    input  logic                              inc_i,
    output logic [addr_width(NUM_ROWS)-1:0]   row_o,
    output logic [addr_width(NUM_COLS)-1:0]   col_o,
    output logic                              final_o
);

    localparam int unsigned ROW_W = addr_width(NUM_ROWS);
    localparam int unsigned COL_W = addr_width(NUM_COLS);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_end, col_end;

    assign row_end = (row_q == ROW_MAX);
    assign col_end = (col_q == COL_MAX);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign final_o = row_end && col_end;

endmodule

// File: rtl/weights_stream_loader.sv
// -----------------------------------------------------------------------------
// weights_stream_loader
// Accepts a valid/ready stream of weight words and writes them row-major into
// the weights RAM write port as a NUM_ROWS x NUM_COLS matrix.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle load request, honoured in IDLE or DONE
//   s        : stream slave (s_valid, s_data, s_last in; s_ready out)
//   wr_en    : RAM write strobe, one cycle after each accepted beat
//   wr_row   : RAM row address
//   wr_col   : RAM column address
//   wr_data  : RAM write data
//   busy     : loading
//   done     : load finished, held until next start or rst
//   err_len  : s_last did not coincide with the final matrix word
// -----------------------------------------------------------------------------
module weights_stream_loader
    import weights_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WEIGHTS_DW,
    parameter int unsigned NUM_COLS   = WEIGHTS_COLS,
    parameter int unsigned NUM_ROWS   = WEIGHTS_ROWS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    weights_stream_loader_if.slave           s,
    output logic                             wr_en,
    output logic [addr_width(NUM_ROWS)-1:0]  wr_row,
    output logic [addr_width(NUM_COLS)-1:0]  wr_col,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             busy,
    output logic                             done,
    output logic                             err_len
);

    localparam int unsigned ROW_W = addr_width(NUM_ROWS);
    localparam int unsigned COL_W = addr_width(NUM_COLS);

    loader_state_e         state_q, state_d;
    logic                  err_q, err_d;
    logic                  wr_en_q;
    logic [ROW_W-1:0]      wr_row_q;
    logic [COL_W-1:0]      wr_col_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic                  accept;
    logic                  cnt_clr;
    logic                  at_final;
    logic [ROW_W-1:0]      cur_row;
    logic [COL_W-1:0]      cur_col;

    weights_addr_counter #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (accept),
        .row_o   (cur_row),
        .col_o   (cur_col),
        .final_o (at_final)
    );

    // Ready is a pure decode of the registered state.
    assign s.s_ready = (state_q == ST_LOAD);
    assign accept    = s.s_ready && s.s_valid;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                // The load ends on the final matrix word or on s_last,
                // whichever comes first; a length error is any disagreement.
                if (accept && (at_final || s.s_last)) begin
                    state_d = ST_DONE;
                    err_d   = (at_final != s.s_last);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wr_en_q <= accept;
            if (accept) begin
                wr_row_q  <= cur_row;
                wr_col_q  <= cur_col;
                wr_data_q <= s.s_data;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_row  = wr_row_q;
    assign wr_col  = wr_col_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == ST_LOAD);
    assign done    = (state_q == ST_DONE);
    assign err_len = err_q;

endmodule

// File: tb/tb_weights_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_weights_stream_loader
// Scoreboard bench for weights_stream_loader: a reference model predicts each
// RAM write (linear beat index -> row/col) and the status flags; a negedge
// monitor pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_weights_stream_loader;
    import weights_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned NW = NR * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wr_en;
    logic [1:0]    wr_row;
    logic [2:0]    wr_col;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err_len;

    weights_stream_loader_if #(.DATA_WIDTH(DW)) s_if ();

    weights_stream_loader #(
        .DATA_WIDTH (DW),
        .NUM_COLS   (NC),
        .NUM_ROWS   (NR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s       (s_if),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   row;
        int unsigned   col;
        logic [DW-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    bit          m_loading = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_err     = 1'b0;
    int unsigned m_count   = 0;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          mon_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is a run of accepted words numbered 0..NW-1,
    // word k belongs at (k / NC, k % NC); it ends at word NW-1 or on s_last.
    always @(posedge clk) begin
        if (rst) begin
            m_loading = 1'b0;
            m_done    = 1'b0;
            m_err     = 1'b0;
        end else if (m_loading) begin
            if (s_if.s_valid) begin
                exp_q.push_back('{row: m_count / NC, col: m_count % NC, data: s_if.s_data});
                m_count++;
                if (m_count == NW || s_if.s_last) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                    m_err     = ((m_count == NW) != s_if.s_last);
                end
            end
        end else if (start) begin
            m_loading = 1'b1;
            m_done    = 1'b0;
            m_err     = 1'b0;
            m_count   = 0;
        end
    end

    // Monitor: status every cycle, and one expected write per wr_en pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            bit  e_valid;
            wr_t e;
            check("s_ready", 32'(s_if.s_ready), 32'(m_loading));
            check("busy",    32'(busy),         32'(m_loading));
            check("done",    32'(done),         32'(m_done));
            check("err_len", 32'(err_len),      32'(m_err));
            e_valid = (exp_q.size() != 0);
            check("wr_en", 32'(wr_en), 32'(e_valid));
            if (e_valid) begin
                e = exp_q.pop_front();
                if (wr_en === 1'b1) begin
                    check("wr_row",  32'(wr_row),  e.row);
                    check("wr_col",  32'(wr_col),  e.col);
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
        end
    end

    task automatic cyc(input bit st, input bit v, input logic [DW-1:0] d,
                       input bit l, input bit r, output bit acc);
        start       = st;
        s_if.s_valid = v;
        s_if.s_data  = d;
        s_if.s_last  = l;
        rst          = r;
        @(posedge clk);
        acc = v && (s_if.s_ready === 1'b1) && !r;
        #1;
        start        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic do_start();
        bit acc;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    // Offer n beats. gap_mode: 0 = valid always, 1 = valid pattern 1,0,0,
    // 2 = random. last_at < 0 means s_last is never raised. start_at pulses
    // start together with that beat. rand_data selects random vs index data.
    task automatic load(input int n, input int last_at, input int gap_mode,
                        input int start_at, input bit rand_data);
        bit acc;
        bit v;
        int i = 0;
        int t = 0;
        logic [DW-1:0] d;
        d = rand_data ? DW'($urandom) : DW'(0);
        while (i < n && t < 500) begin
            case (gap_mode)
                1:       v = (t % 3 == 0);
                2:       v = ($urandom_range(0, 1) == 1);
                default: v = 1'b1;
            endcase
            cyc((i == start_at) && v, v, d, v && (i == last_at), 1'b0, acc);
            if (acc) begin
                i++;
                d = rand_data ? DW'($urandom) : DW'(i);
            end
            t++;
        end
        check("beats_accepted", 32'(i), 32'(n));
    endtask

    task automatic check_reset();
        check("rst_wr_en",   32'(wr_en),        32'(0));
        check("rst_wr_row",  32'(wr_row),       32'(0));
        check("rst_wr_col",  32'(wr_col),       32'(0));
        check("rst_wr_data", 32'(wr_data),      32'(0));
        check("rst_busy",    32'(busy),         32'(0));
        check("rst_done",    32'(done),         32'(0));
        check("rst_err_len", 32'(err_len),      32'(0));
        check("rst_s_ready", 32'(s_if.s_ready), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int mode;
        int la;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;

        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
        check_reset();
        mon_en = 1'b1;

        // Beats offered while idle are not accepted.
        cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, acc);
        idle(1);

        // Full load, data = index, s_last on the final beat.
        do_start();
        load(32, 31, 0, -1, 1'b0);
        check("full_done",    32'(done),    32'(1));
        check("full_err_len", 32'(err_len), 32'(0));
        check("full_busy",    32'(busy),    32'(0));
        idle(2);

        // Backpressure gaps 1,0,0,...
        do_start();
        load(32, 31, 1, -1, 1'b1);
        idle(2);

        // Early s_last on beat 10, then beat 11 must not be taken.
        do_start();
        load(11, 10, 0, -1, 1'b0);
        check("early_err_len", 32'(err_len), 32'(1));
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'd11, 1'b0, 1'b0, acc);
        idle(1);

        // Missing s_last.
        do_start();
        load(32, -1, 0, -1, 1'b1);
        check("nolast_err_len", 32'(err_len), 32'(1));
        idle(1);

        // Reset after beat 15 with s_valid still high.
        do_start();
        load(16, -1, 0, -1, 1'b0);
        cyc(1'b0, 1'b1, 8'd16, 1'b0, 1'b1, acc);
        check_reset();
        do_start();
        load(32, 31, 0, -1, 1'b0);
        idle(1);

        // start mid-load is ignored; start in DONE restarts cleanly.
        do_start();
        load(32, -1, 0, 5, 1'b1);
        check("midstart_err_len", 32'(err_len), 32'(1));
        do_start();
        check("restart_done",    32'(done),    32'(0));
        check("restart_err_len", 32'(err_len), 32'(0));
        load(32, 31, 2, -1, 1'b1);
        idle(2);

        // Random loads: good, early-last, or missing-last.
        for (int k = 0; k < 8; k++) begin
            mode = int'($urandom_range(0, 2));
            do_start();
            if (mode == 0) begin
                load(32, 31, 2, -1, 1'b1);
            end else if (mode == 1) begin
                la = int'($urandom_range(0, 30));
                load(la + 1, la, 2, -1, 1'b1);
            end else begin
                load(32, -1, 2, -1, 1'b1);
            end
            idle(int'($urandom_range(1, 3)));
        end

        idle(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
